// File: rtl/bram_fifo_fwft.sv
// -----------------------------------------------------------------------------
// bram_fifo_fwft
//
// Synchronous stream FIFO built around a dual-port block-RAM array. One port
// writes incoming words; the other reads through a registered address, so
// RAM data arrives one cycle after a fetch is issued. A two-register output
// stage (head + skid) hides that latency and presents a first-word-fall-
// through valid/ready interface to the consumer.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   producer offers in_data
//   in_ready   FIFO can accept a word (depends on registered level only)
//   in_data    write word
//   out_valid  out_data holds the oldest unread word
//   out_ready  consumer takes out_data
//   out_data   head word
//   level      words accepted and not yet consumed, 0..DEPTH
// -----------------------------------------------------------------------------
module bram_fifo_fwft #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W:0]   level
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] LEVEL_FULL = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic {
      STAGE_EMPTY,
      STAGE_VALID
   } stage_state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W:0]   ram_count;
   logic              fetch_inflight;

   stage_state_t      head_state;
   stage_state_t      skid_state;
   logic [DATA_W-1:0] head_data;
   logic [DATA_W-1:0] skid_data;

   logic [DATA_W-1:0] ram_rdata;
   logic              accept;
   logic              consume;
   logic              issue;
   logic [1:0]        stage_count;

   // Handshake qualifiers. in_ready looks only at the registered level, so a
   // consume at full frees a slot one cycle later rather than combinationally.
   assign in_ready  = !reset && (level != LEVEL_FULL);
   assign out_valid = (head_state == STAGE_VALID);
   assign out_data  = head_data;
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;

   // Words already pulled out of the RAM: sitting in head, sitting in skid, or
   // on their way back from the read port. The two output registers can hold
   // at most two, so a new fetch is only allowed while fewer than two are
   // committed, or exactly two with one leaving this edge.
   assign stage_count = {1'b0, head_state == STAGE_VALID}
                      + {1'b0, skid_state == STAGE_VALID}
                      + {1'b0, fetch_inflight};

   assign issue = (ram_count != '0)
               && ((stage_count < 2'd2) || ((stage_count == 2'd2) && consume));

   // Read port of the array: the address is registered, so the word for a
   // fetch issued on one edge is available during the following cycle.
   assign ram_rdata = mem[rd_addr_q];

   // Write port of the array. Contents are never cleared; stale entries are
   // harmless because reads only touch written, unfetched slots.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Read address register. Loaded whenever a fetch is issued.
   always_ff @(posedge clk) begin
      if (issue) begin
         rd_addr_q <= rd_ptr;
      end
   end

   // Pointers and occupancy counters. Pointers wrap naturally at DEPTH.
   // level tracks everything accepted but not consumed; ram_count tracks only
   // what is still waiting in the array to be fetched.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         ram_count      <= '0;
         fetch_inflight <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fetch_inflight <= issue;

         case ({accept, consume})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase

         case ({accept, issue})
            2'b10:   ram_count <= ram_count + 1'b1;
            2'b01:   ram_count <= ram_count - 1'b1;
            default: ram_count <= ram_count;
         endcase
      end
   end

   // Output stage. Returning RAM data lands in head when head is free (empty
   // or leaving this edge with nothing in skid), otherwise it parks in skid.
   // On a consume, skid moves up into head. Skid full and a word in flight
   // together never happens because the fetch gate caps the total at two.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_state <= STAGE_EMPTY;
         skid_state <= STAGE_EMPTY;
         head_data  <= '0;
         skid_data  <= '0;
      end else if (consume) begin
         if (skid_state == STAGE_VALID) begin
            head_data  <= skid_data;
            head_state <= STAGE_VALID;
            skid_state <= STAGE_EMPTY;
         end else if (fetch_inflight) begin
            head_data  <= ram_rdata;
            head_state <= STAGE_VALID;
         end else begin
            head_state <= STAGE_EMPTY;
         end
      end else if (fetch_inflight) begin
         if (head_state == STAGE_EMPTY) begin
            head_data  <= ram_rdata;
            head_state <= STAGE_VALID;
         end else begin
            skid_data  <= ram_rdata;
            skid_state <= STAGE_VALID;
         end
      end
   end

endmodule

// File: tb/tb_bram_fifo_fwft.sv
// -----------------------------------------------------------------------------
// tb_bram_fifo_fwft
//
// Directed self-checking bench for bram_fifo_fwft with DATA_W=8, ADDR_W=2
// (DEPTH=4). Inputs change 1 time unit after a rising edge and outputs are
// sampled at that same point, so every check sees the state left by the edge
// that was just applied.
// -----------------------------------------------------------------------------
module tb_bram_fifo_fwft;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W:0]   level;

   int compared_count;
   int mismatch_count;

   bram_fifo_fwft #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared_count++;
      if (observed != expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drive one cycle worth of inputs, let one rising edge happen, and return
   // just after it so outputs reflect that edge.
   task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic r);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   // Check out_valid/out_data/level together.
   task automatic checkHead(input string tag, input logic exp_valid,
                            input logic [DATA_W-1:0] exp_data, input int exp_level);
      checkOutput({tag, "_valid"}, int'(out_valid), int'(exp_valid));
      if (exp_valid) begin
         checkOutput({tag, "_data"}, int'(out_data), int'(exp_data));
      end
      checkOutput({tag, "_level"}, int'(level), exp_level);
   endtask

   // Directed scenarios.
   initial begin
      int exp_level;
      int accepted;
      int consumed;

      compared_count = 0;
      mismatch_count = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset held for two edges.
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("rst_in_ready", int'(in_ready), 0);
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_out_data", int'(out_data), 8'h00);
      checkOutput("rst_level", int'(level), 0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("rst2_in_ready", int'(in_ready), 0);
      reset = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", int'(in_ready), 1);

      // Single word: accepted at edge k, visible after edge k+2.
      applyStimulus(1'b1, 8'h11, 1'b0);
      checkHead("single_k", 1'b0, 8'h00, 1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkHead("single_k1", 1'b0, 8'h00, 1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkHead("single_k2", 1'b1, 8'h11, 1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkHead("single_hold", 1'b1, 8'h11, 1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkHead("single_pop", 1'b0, 8'h00, 0);

      // Fill to DEPTH with the consumer stalled, then offer one extra word.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
         checkOutput("fill_level", int'(level), i + 1);
      end
      checkOutput("fill_in_ready", int'(in_ready), 0);
      applyStimulus(1'b1, 8'hA4, 1'b0);
      checkOutput("overfill_level", int'(level), 4);
      checkOutput("overfill_in_ready", int'(in_ready), 0);
      for (int i = 0; i < 4; i++) begin
         checkHead("drain", 1'b1, 8'hA0 + 8'(i), 4 - i);
         applyStimulus(1'b0, 8'h00, 1'b1);
      end
      checkHead("drain_done", 1'b0, 8'h00, 0);

      // Streaming: 16 words in with the consumer always ready. Output i shows
      // up after write edge i+2; level is accepts minus consumes so far.
      for (int i = 0; i < 19; i++) begin
         applyStimulus((i < 16) ? 1'b1 : 1'b0, 8'(i), 1'b1);
         accepted  = (i + 1 < 16) ? i + 1 : 16;
         consumed  = (i - 2 > 0) ? i - 2 : 0;
         exp_level = accepted - consumed;
         checkHead("stream", (i >= 2 && i <= 17) ? 1'b1 : 1'b0, 8'(i - 2), exp_level);
         if (i < 16) begin
            checkOutput("stream_in_ready", int'(in_ready), 1);
         end
      end

      // Full with a single-cycle consume: in_ready returns one cycle later
      // and a follow-up write refills to DEPTH.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0);
      end
      checkOutput("full_level", int'(level), 4);
      checkOutput("full_in_ready", int'(in_ready), 0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("full_pop_level", int'(level), 3);
      checkOutput("full_pop_in_ready", int'(in_ready), 1);
      applyStimulus(1'b1, 8'hB4, 1'b0);
      checkOutput("refill_level", int'(level), 4);
      checkOutput("refill_in_ready", int'(in_ready), 0);
      for (int i = 0; i < 4; i++) begin
         checkHead("refill_drain", 1'b1, 8'hB1 + 8'(i), 4 - i);
         applyStimulus(1'b0, 8'h00, 1'b1);
      end
      checkHead("refill_done", 1'b0, 8'h00, 0);

      // Mid-operation reset with a word in head and one in flight.
      applyStimulus(1'b1, 8'hC0, 1'b0);
      applyStimulus(1'b1, 8'hC1, 1'b0);
      applyStimulus(1'b1, 8'hC2, 1'b0);
      checkHead("pre_rst", 1'b1, 8'hC0, 3);
      reset = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkHead("mid_rst", 1'b0, 8'h00, 0);
      checkOutput("mid_rst_out_data", int'(out_data), 8'h00);
      checkOutput("mid_rst_in_ready", int'(in_ready), 0);
      reset = 1'b0;
      applyStimulus(1'b1, 8'h55, 1'b0);
      checkHead("after_rst_k", 1'b0, 8'h00, 1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkHead("after_rst_k1", 1'b0, 8'h00, 1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkHead("after_rst_k2", 1'b1, 8'h55, 1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkHead("after_rst_pop", 1'b0, 8'h00, 0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkHead("no_stale", 1'b0, 8'h00, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
      $finish;
   end

endmodule
